// File: rtl/gcd_avalon_bin.sv
// gcd_avalon_bin: Avalon-MM slave that computes the GCD of two WIDTH-bit
// unsigned operands with the binary (Stein) algorithm, one step per clock.
// Register map: 0 A, 1 B, 2 RESULT, 3 STATUS, 4 CTRL, 5 CYC, 6/7 read 0.
// Optional feature: define GCD_IRQ_EN to add the irq output and the
// CTRL.irq_en bit; without it CTRL bit1 reads 0 and there is no irq port.
module gcd_avalon_bin #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  output logic [31:0] readdata,
  input  logic [31:0] writedata,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic        chipselect
`ifdef GCD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_COMMON = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        reg_a_q, reg_a_d;
  logic [WIDTH-1:0]        reg_b_q, reg_b_d;
  logic [WIDTH-1:0]        ea_q, ea_d;
  logic [WIDTH-1:0]        eb_q, eb_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic                    zero_err_q, zero_err_d;
  logic                    ovr_q, ovr_d;
  logic                    irq_pend_q, irq_pend_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    irq_en;

  logic                    busy, done;
  logic                    wr_a, wr_b, wr_st, wr_ctrl, rd_en, abort;
  logic [WIDTH-1:0]        a_merged, b_merged;
  logic [31:0]             rd_word;

  // Byte-lane merge of a write into a WIDTH-bit register; bits above WIDTH drop.
  function automatic logic [WIDTH-1:0] merge_be(input logic [WIDTH-1:0] old_v,
                                                input logic [31:0]      wd,
                                                input logic [3:0]       be);
    logic [31:0] tmp;
    tmp = '0;
    tmp[WIDTH-1:0] = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) tmp[i*8 +: 8] = wd[i*8 +: 8];
    end
    return tmp[WIDTH-1:0];
  endfunction

  assign busy     = (state_q == S_CHECK) || (state_q == S_COMMON) || (state_q == S_REDUCE);
  assign done     = (state_q == S_DONE);
  assign rd_en    = chipselect & read;
  assign wr_a     = chipselect & write & (address == 3'd0);
  assign wr_b     = chipselect & write & (address == 3'd1);
  assign wr_st    = chipselect & write & (address == 3'd3) & byteenable[0];
  assign wr_ctrl  = chipselect & write & (address == 3'd4) & byteenable[0];
  assign abort    = wr_ctrl & writedata[0];
  assign a_merged = merge_be(reg_a_q, writedata, byteenable);
  assign b_merged = merge_be(reg_b_q, writedata, byteenable);
  assign readdata = readdata_q;

`ifdef GCD_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // Interrupt enable register and registered interrupt output.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl) irq_en_d = writedata[1];
    irq_d = irq_pend_q & irq_en_q;
  end

  // Interrupt state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  // Read-data mux; unused upper bits read 0.
  always_comb begin
    rd_word = '0;
    case (address)
      3'd0: rd_word[WIDTH-1:0] = reg_a_q;
      3'd1: rd_word[WIDTH-1:0] = reg_b_q;
      3'd2: rd_word[WIDTH-1:0] = result_q;
      3'd3: rd_word[4:0]       = {irq_pend_q, ovr_q, zero_err_q, busy, done};
      3'd4: rd_word[1]         = irq_en;
      3'd5: rd_word[CNT_W-1:0] = cyc_q;
      default: rd_word = '0;
    endcase
  end

  // Register writes, W1C status, and the Stein engine next-state logic.
  always_comb begin
    state_d    = state_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    k_d        = k_q;
    result_d   = result_q;
    cyc_d      = cyc_q;
    zero_err_d = zero_err_q;
    ovr_d      = ovr_q;
    irq_pend_d = irq_pend_q;
    readdata_d = rd_en ? rd_word : readdata_q;

    // W1C first so that a same-cycle set event wins.
    if (wr_st) begin
      if (writedata[3]) ovr_d      = 1'b0;
      if (writedata[4]) irq_pend_d = 1'b0;
    end

    // Operand writes while the engine runs are dropped and flagged.
    if (busy && (wr_a || wr_b)) ovr_d = 1'b1;
    if (!busy && wr_a) reg_a_d = a_merged;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (wr_b) begin
          reg_b_d    = b_merged;
          ea_d       = reg_a_q;
          eb_d       = b_merged;
          k_d        = '0;
          cyc_d      = '0;
          zero_err_d = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK, S_COMMON, S_REDUCE: begin
        if (cyc_q != {CNT_W{1'b1}}) cyc_d = cyc_q + 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (state_q == S_CHECK) begin
          if (ea_q == '0 && eb_q == '0) begin
            result_d   = '0;
            zero_err_d = 1'b1;
            state_d    = S_DONE;
          end else if (ea_q == '0) begin
            result_d = eb_q;
            state_d  = S_DONE;
          end else if (eb_q == '0) begin
            result_d = ea_q;
            state_d  = S_DONE;
          end else if (!ea_q[0] && !eb_q[0]) begin
            state_d = S_COMMON;
          end else begin
            // COMMON would exit immediately with an odd operand, so skip it.
            state_d = S_REDUCE;
          end
        end else if (state_q == S_COMMON) begin
          if (!ea_q[0] && !eb_q[0]) begin
            ea_d = ea_q >> 1;
            eb_d = eb_q >> 1;
            k_d  = k_q + 1'b1;
          end else begin
            state_d = S_REDUCE;
          end
        end else begin
          if (ea_q == eb_q) begin
            result_d = ea_q << k_q;
            state_d  = S_DONE;
          end else if (!ea_q[0]) begin
            ea_d = ea_q >> 1;
          end else if (!eb_q[0]) begin
            eb_d = eb_q >> 1;
          end else if (ea_q > eb_q) begin
            ea_d = (ea_q - eb_q) >> 1;
          end else begin
            eb_d = (eb_q - ea_q) >> 1;
          end
        end
        if (state_d == S_DONE) irq_pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register file flops; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      k_q        <= '0;
      result_q   <= '0;
      cyc_q      <= '0;
      zero_err_q <= 1'b0;
      ovr_q      <= 1'b0;
      irq_pend_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      k_q        <= k_d;
      result_q   <= result_d;
      cyc_q      <= cyc_d;
      zero_err_q <= zero_err_d;
      ovr_q      <= ovr_d;
      irq_pend_q <= irq_pend_d;
      readdata_q <= readdata_d;
    end
  end

endmodule
